// File: rtl/mem_port_if.sv
// External memory bus seen by mem_port: one valid/ready request channel with
// word address, byte strobes, write data and read data returned on the accepting cycle.
interface mem_port_if #(
  parameter int XLEN = 32
);
  logic            bus_valid;
  logic            bus_ready;
  logic            bus_we;
  logic [XLEN-1:0] bus_addr;
  logic [3:0]      bus_wstrb;
  logic [XLEN-1:0] bus_wdata;
  logic [XLEN-1:0] bus_rdata;

  modport master (
    output bus_valid, bus_we, bus_addr, bus_wstrb, bus_wdata,
    input  bus_ready, bus_rdata
  );

  modport slave (
    input  bus_valid, bus_we, bus_addr, bus_wstrb, bus_wdata,
    output bus_ready, bus_rdata
  );
endinterface

// File: rtl/mem_port.sv
// Memory-side sequencer: turns control's read/write strobes into one bus
// transaction, aligns/extends load data and rejects misaligned data accesses.
module mem_port #(
  parameter int XLEN = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_rden,
  input  logic             mem_wren,
  input  logic             memop,
  input  logic [2:0]       funct3,
  input  logic [XLEN-1:0]  addr,
  input  logic [XLEN-1:0]  wdata,
  output logic             done,
  output logic [XLEN-1:0]  rdata,
  output logic             misaligned,
  mem_port_if.master       bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    FIN  = 2'd2,
    ERR  = 2'd3
  } state_t;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  state_t          state;
  logic            bus_valid_q;
  logic            bus_we_q;
  logic [XLEN-1:0] bus_addr_q;
  logic [3:0]      bus_wstrb_q;
  logic [XLEN-1:0] bus_wdata_q;
  logic [XLEN-1:0] rdata_q;
  logic            misaligned_q;
  logic [1:0]      lo_q;
  logic [1:0]      size_q;
  logic            uns_q;

  logic            req;
  logic            req_we;
  logic [2:0]      eff_f3;
  logic [1:0]      size;
  logic            is_mis;

  function automatic logic [3:0] lane_strb(input logic [1:0] sz, input logic [1:0] lo);
    logic [3:0] s;
    case (sz)
      SZ_B:    s = 4'b0001 << lo;
      SZ_H:    s = 4'b0011 << {lo[1], 1'b0};
      default: s = 4'b1111;
    endcase
    return s;
  endfunction

  function automatic logic [XLEN-1:0] lane_data(input logic [1:0] sz, input logic [XLEN-1:0] d);
    logic [XLEN-1:0] r;
    case (sz)
      SZ_B:    r = {4{d[7:0]}};
      SZ_H:    r = {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic logic [XLEN-1:0] load_align(input logic [XLEN-1:0] word,
                                                 input logic [1:0]      lo,
                                                 input logic [1:0]      sz,
                                                 input logic            uns);
    logic [7:0]      b;
    logic [15:0]     h;
    logic [XLEN-1:0] r;
    b = word[{lo, 3'b000} +: 8];
    h = lo[1] ? word[31:16] : word[15:0];
    case (sz)
      SZ_B:    r = uns ? {{(XLEN-8){1'b0}}, b} : {{(XLEN-8){b[7]}}, b};
      SZ_H:    r = uns ? {{(XLEN-16){1'b0}}, h} : {{(XLEN-16){h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Fetches are always word-sized; unknown funct3 size codes fall back to a word.
  assign req    = mem_rden | mem_wren;
  assign req_we = mem_wren;
  assign eff_f3 = memop ? funct3 : 3'b010;
  assign size   = eff_f3[1] ? SZ_W : eff_f3[1:0];
  assign is_mis = ((size == SZ_H) && addr[0]) ||
                  ((size == SZ_W) && (addr[1:0] != 2'b00));

  assign done = (state == IDLE) ? !req : ((state == FIN) || (state == ERR));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      bus_valid_q  <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_addr_q   <= '0;
      bus_wstrb_q  <= 4'b0000;
      bus_wdata_q  <= '0;
      rdata_q      <= '0;
      misaligned_q <= 1'b0;
      lo_q         <= 2'b00;
      size_q       <= SZ_W;
      uns_q        <= 1'b0;
    end else begin
      misaligned_q <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            if (is_mis) begin
              state        <= ERR;
              misaligned_q <= 1'b1;
            end else begin
              state       <= BUS;
              bus_valid_q <= 1'b1;
              bus_we_q    <= req_we;
              bus_addr_q  <= {addr[XLEN-1:2], 2'b00};
              bus_wstrb_q <= req_we ? lane_strb(size, addr[1:0]) : 4'b0000;
              bus_wdata_q <= lane_data(size, wdata);
              lo_q        <= addr[1:0];
              size_q      <= size;
              uns_q       <= eff_f3[2];
            end
          end
        end
        // Bus outputs stay frozen here until the slave accepts.
        BUS: begin
          if (bus.bus_ready) begin
            state       <= FIN;
            bus_valid_q <= 1'b0;
            if (!bus_we_q) begin
              rdata_q <= load_align(bus.bus_rdata, lo_q, size_q, uns_q);
            end
          end
        end
        FIN:     state <= IDLE;
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.bus_valid = bus_valid_q;
  assign bus.bus_we    = bus_we_q;
  assign bus.bus_addr  = bus_addr_q;
  assign bus.bus_wstrb = bus_wstrb_q;
  assign bus.bus_wdata = bus_wdata_q;
  assign rdata         = rdata_q;
  assign misaligned    = misaligned_q;

endmodule

// File: tb/tb_mem_port.sv
// Directed bench for mem_port: table of single accesses plus hand-written
// wait-state, back-to-back and reset-abandonment sequences.
module tb_mem_port;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_rden = 1'b0;
  logic        mem_wren = 1'b0;
  logic        memop = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        done;
  logic [31:0] rdata;
  logic        misaligned;

  int checks = 0;
  int errors = 0;

  mem_port_if #(.XLEN(32)) bus ();

  mem_port #(.XLEN(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_rden   (mem_rden),
    .mem_wren   (mem_wren),
    .memop      (memop),
    .funct3     (funct3),
    .addr       (addr),
    .wdata      (wdata),
    .done       (done),
    .rdata      (rdata),
    .misaligned (misaligned),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rden;
    logic        wren;
    logic        memop;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] brdata;
    logic [31:0] exp_rdata;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_strb;
    logic        exp_we;
    logic        exp_mis;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Called #1 after a rising edge with the FSM idle; returns at the same phase, idle again.
  task automatic do_vec(input int idx, input vec_t v);
    mem_rden = v.rden;
    mem_wren = v.wren;
    memop    = v.memop;
    funct3   = v.f3;
    addr     = v.addr;
    wdata    = v.wdata;
    #1;
    chk($sformatf("v%0d done_low_on_req", idx), {31'd0, done}, 32'd0);
    @(posedge clk); #1;
    if (v.exp_mis) begin
      chk($sformatf("v%0d mis_no_valid", idx), {31'd0, bus.bus_valid}, 32'd0);
      chk($sformatf("v%0d mis_done", idx), {31'd0, done}, 32'd1);
      chk($sformatf("v%0d mis_flag", idx), {31'd0, misaligned}, 32'd1);
      chk($sformatf("v%0d mis_rdata", idx), rdata, v.exp_rdata);
    end else begin
      chk($sformatf("v%0d valid", idx), {31'd0, bus.bus_valid}, 32'd1);
      chk($sformatf("v%0d addr", idx), bus.bus_addr, v.exp_addr);
      chk($sformatf("v%0d we", idx), {31'd0, bus.bus_we}, {31'd0, v.exp_we});
      chk($sformatf("v%0d wstrb", idx), {28'd0, bus.bus_wstrb}, {28'd0, v.exp_strb});
      if (v.exp_we) chk($sformatf("v%0d wdata", idx), bus.bus_wdata, v.exp_wdata);
      chk($sformatf("v%0d done_busy", idx), {31'd0, done}, 32'd0);
      bus.bus_ready = 1'b1;
      bus.bus_rdata = v.brdata;
      @(posedge clk); #1;
      bus.bus_ready = 1'b0;
      bus.bus_rdata = 32'h0;
      chk($sformatf("v%0d done", idx), {31'd0, done}, 32'd1);
      chk($sformatf("v%0d valid_dropped", idx), {31'd0, bus.bus_valid}, 32'd0);
      chk($sformatf("v%0d no_mis", idx), {31'd0, misaligned}, 32'd0);
      chk($sformatf("v%0d rdata", idx), rdata, v.exp_rdata);
    end
    mem_rden = 1'b0;
    mem_wren = 1'b0;
    @(posedge clk); #1;
    chk($sformatf("v%0d idle_done", idx), {31'd0, done}, 32'd1);
    chk($sformatf("v%0d idle_mis", idx), {31'd0, misaligned}, 32'd0);
  endtask

  initial begin
    //            rd    wr    memop f3      addr          wdata         brdata        exp_rdata     exp_addr      exp_wdata     strb     we    mis
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 3'b000, 32'h0000_0104, 32'h0,        32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0000_0104, 32'h0,        4'b0000, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b1, 3'b000, 32'h0000_0203, 32'h0,        32'h8012_3456, 32'hFFFF_FF80, 32'h0000_0200, 32'h0,        4'b0000, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b1, 3'b100, 32'h0000_0203, 32'h0,        32'h8012_3456, 32'h0000_0080, 32'h0000_0200, 32'h0,        4'b0000, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'h0,        32'h8001_1234, 32'hFFFF_8001, 32'h0000_0200, 32'h0,        4'b0000, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 1'b1, 3'b101, 32'h0000_0200, 32'h0,        32'h1234_F00D, 32'h0000_F00D, 32'h0000_0200, 32'h0,        4'b0000, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 1'b1, 3'b000, 32'h0000_0201, 32'h0,        32'h0000_7F00, 32'h0000_007F, 32'h0000_0200, 32'h0,        4'b0000, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 3'b000, 32'h0000_0301, 32'h1234_56AB, 32'h0,        32'h0000_007F, 32'h0000_0300, 32'hABAB_ABAB, 4'b0010, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 3'b001, 32'h0000_0302, 32'h0000_BEEF, 32'h0,        32'h0000_007F, 32'h0000_0300, 32'hBEEF_BEEF, 4'b1100, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 3'b010, 32'h0000_0308, 32'hCAFE_F00D, 32'h0,        32'h0000_007F, 32'h0000_0308, 32'hCAFE_F00D, 4'b1111, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 1'b1, 3'b000, 32'h0000_030C, 32'h0000_0055, 32'hFFFF_FFFF, 32'h0000_007F, 32'h0000_030C, 32'h5555_5555, 4'b0001, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 1'b1, 3'b010, 32'h0000_0402, 32'h0,        32'h0,        32'h0000_007F, 32'h0,        32'h0,        4'b0000, 1'b0, 1'b1};
    vecs[11] = '{1'b0, 1'b1, 1'b1, 3'b001, 32'h0000_0401, 32'h0000_1234, 32'h0,        32'h0000_007F, 32'h0,        32'h0,        4'b0000, 1'b0, 1'b1};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 3'b000, 32'h0000_0402, 32'h0,        32'h0,        32'h0000_007F, 32'h0,        32'h0,        4'b0000, 1'b0, 1'b1};
    vecs[13] = '{1'b1, 1'b0, 1'b1, 3'b011, 32'h0000_0400, 32'h0,        32'h89AB_CDEF, 32'h89AB_CDEF, 32'h0000_0400, 32'h0,        4'b0000, 1'b0, 1'b0};
    vecs[14] = '{1'b1, 1'b0, 1'b1, 3'b101, 32'h0000_0203, 32'h0,        32'h0,        32'h89AB_CDEF, 32'h0,        32'h0,        4'b0000, 1'b0, 1'b1};
  end

  initial begin
    bus.bus_ready = 1'b0;
    bus.bus_rdata = 32'h0;

    // Asynchronous reset, checked before any clock edge
    #2 rst = 1'b1;
    #1;
    chk("rst_valid", {31'd0, bus.bus_valid}, 32'd0);
    chk("rst_we", {31'd0, bus.bus_we}, 32'd0);
    chk("rst_wstrb", {28'd0, bus.bus_wstrb}, 32'd0);
    chk("rst_addr", bus.bus_addr, 32'd0);
    chk("rst_wdata", bus.bus_wdata, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_mis", {31'd0, misaligned}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_done", {31'd0, done}, 32'd1);

    for (int i = 0; i < NV; i++) do_vec(i, vecs[i]);

    // Store with three wait states; request held through FIN and one cycle beyond
    mem_wren = 1'b1; mem_rden = 1'b0; memop = 1'b1; funct3 = 3'b010;
    addr = 32'h0000_0504; wdata = 32'h0BAD_F00D;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("ws%0d valid", k), {31'd0, bus.bus_valid}, 32'd1);
      chk($sformatf("ws%0d addr", k), bus.bus_addr, 32'h0000_0504);
      chk($sformatf("ws%0d wdata", k), bus.bus_wdata, 32'h0BAD_F00D);
      chk($sformatf("ws%0d wstrb", k), {28'd0, bus.bus_wstrb}, 32'h0000_000F);
      chk($sformatf("ws%0d done", k), {31'd0, done}, 32'd0);
      addr = 32'h0000_0FF0 + 32'(k); wdata = 32'h1111_1111 * 32'(k + 1);
      @(posedge clk); #1;
    end
    chk("ws_valid_held", {31'd0, bus.bus_valid}, 32'd1);
    chk("ws_addr_held", bus.bus_addr, 32'h0000_0504);
    bus.bus_ready = 1'b1;
    @(posedge clk); #1;
    bus.bus_ready = 1'b0;
    chk("ws_done", {31'd0, done}, 32'd1);
    chk("ws_rdata_kept", rdata, 32'h89AB_CDEF);
    @(posedge clk); #1;
    chk("ws_single_done", {31'd0, done}, 32'd0);
    chk("ws_no_reaccept", {31'd0, bus.bus_valid}, 32'd0);
    mem_wren = 1'b0;
    #1;
    chk("ws_idle_done", {31'd0, done}, 32'd1);
    @(posedge clk); #1;
    chk("ws_idle_valid", {31'd0, bus.bus_valid}, 32'd0);

    // Reset while a read is outstanding on the bus
    mem_rden = 1'b1; memop = 1'b0; funct3 = 3'b000; addr = 32'h0000_0600;
    @(posedge clk); #1;
    chk("rb_valid", {31'd0, bus.bus_valid}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rb_valid_async", {31'd0, bus.bus_valid}, 32'd0);
    chk("rb_rdata_async", rdata, 32'd0);
    mem_rden = 1'b0;
    #1;
    chk("rb_done_in_rst", {31'd0, done}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rb_idle_done", {31'd0, done}, 32'd1);
    chk("rb_idle_valid", {31'd0, bus.bus_valid}, 32'd0);
    do_vec(99, vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
